input_symbol_feeder: RTL and testbench

//  Upstream front end of the AV1 arithmetic-encoder pipeline. Buffers symbol records
//  (FL, FH, symbol, nsyms, bool, last) from the host/bench with a valid/ready handshake.

---
 rtl/enc_pkg.sv | 26 ++
 rtl/sync_fifo_sa.sv | 67 ++++++
 rtl/input_symbol_feeder.sv | 104 ++++++++++
 tb/tb_input_symbol_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared widths, symbol record and feeder state encoding
package enc_pkg;

    localparam int RANGE_W = 16;
    localparam int SYM_W   = 4;
    localparam int NSYMS_W = 5;

    // Symbol record, shared with Stage 1.
    typedef struct packed {
        logic [RANGE_W-1:0] fl;
        logic [RANGE_W-1:0] fh;
        logic [SYM_W-1:0]   symbol;
        logic [NSYMS_W-1:0] nsyms;
        logic               bool;
        logic               last;
    } sym_rec_t;

    localparam int SYM_REC_W = $bits(sym_rec_t);

    typedef enum logic [1:0] {
        FEED_RUN   = 2'd0,
        FEED_DRAIN = 2'd1,
        FEED_DONE  = 2'd2
    } feed_state_t;

endpackage

// File: rtl/sync_fifo_sa.sv
// rtl/sync_fifo_sa.sv - show-ahead synchronous FIFO
// Ports:
//   clk, reset        clock, asynchronous active-high reset (pointers/count only)
//   push, wdata       write request and data; ignored when full
//   pop               read request; ignored when empty
//   rdata             head entry, combinational from the read pointer
//   count             occupancy 0..DEPTH
//   full, empty       occupancy flags
module sync_fifo_sa #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    import enc_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage is deliberately not reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_symbol_feeder.sv
// rtl/input_symbol_feeder.sv - buffers symbol records and issues one per load_en
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready, in_*    host record handshake and fields
//   load_en                    Stage 1 capture strobe (pipeline_reg_1_2)
//   out_valid, out_*           FIFO head record (show-ahead)
//   fifo_count                 occupancy
//   bubble_cnt                 saturating count of load_en strobes seen with an empty FIFO
//   stream_done                one-cycle pulse after the last record is issued
module input_symbol_feeder
    import enc_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int SYM_W   = enc_pkg::SYM_W,
    parameter int RANGE_W = enc_pkg::RANGE_W,
    parameter int BUB_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RANGE_W-1:0]       in_fl,
    input  logic [RANGE_W-1:0]       in_fh,
    input  logic [SYM_W-1:0]         in_symbol,
    input  logic [NSYMS_W-1:0]       in_nsyms,
    input  logic                     in_bool,
    input  logic                     in_last,
    input  logic                     load_en,
    output logic                     out_valid,
    output logic [RANGE_W-1:0]       out_fl,
    output logic [RANGE_W-1:0]       out_fh,
    output logic [SYM_W-1:0]         out_symbol,
    output logic [NSYMS_W-1:0]       out_nsyms,
    output logic                     out_bool,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [BUB_W-1:0]         bubble_cnt,
    output logic                     stream_done
);

    localparam int REC_W = 2*RANGE_W + SYM_W + NSYMS_W + 2;

    feed_state_t      state;
    feed_state_t      state_nxt;
    logic [REC_W-1:0] wr_rec;
    logic [REC_W-1:0] rd_rec;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign wr_rec = {in_fl, in_fh, in_symbol, in_nsyms, in_bool, in_last};
    assign {out_fl, out_fh, out_symbol, out_nsyms, out_bool, out_last} = rd_rec;

    // No bypass: a pop in the same cycle as full does not open in_ready.
    assign in_ready    = (state == FEED_RUN) & ~full;
    assign out_valid   = ~empty;
    assign push        = in_valid & in_ready;
    assign pop         = load_en & out_valid;
    assign stream_done = (state == FEED_DONE);

    sync_fifo_sa #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (rd_rec),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FEED_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FEED_RUN:   if (push && in_last)  state_nxt = FEED_DRAIN;
            FEED_DRAIN: if (pop && out_last)  state_nxt = FEED_DONE;
            FEED_DONE:  state_nxt = FEED_RUN;
            default:    state_nxt = FEED_RUN;
        endcase
    end

    // A bubble is a load_en strobe that finds nothing to issue; the counter holds at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (load_en && empty && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + BUB_W'(1);
        end
    end

endmodule

// File: tb/tb_input_symbol_feeder.sv
// tb/tb_input_symbol_feeder.sv - scoreboard bench for input_symbol_feeder
module tb_input_symbol_feeder;
    import enc_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_fl = '0;
    logic [15:0] in_fh = '0;
    logic [3:0]  in_symbol = '0;
    logic [4:0]  in_nsyms = '0;
    logic        in_bool = 1'b0;
    logic        in_last = 1'b0;
    logic        load_en = 1'b0;

    logic        in_ready, out_valid, out_bool, out_last, stream_done;
    logic [15:0] out_fl, out_fh;
    logic [3:0]  out_symbol;
    logic [4:0]  out_nsyms;
    logic [4:0]  fifo_count;
    logic [15:0] bubble_cnt;

    logic        in_ready2, out_valid2, out_bool2, out_last2, stream_done2;
    logic [15:0] out_fl2, out_fh2;
    logic [3:0]  out_symbol2;
    logic [4:0]  out_nsyms2;
    logic [4:0]  fifo_count2;
    logic [1:0]  bubble_cnt2;

    always #5 clk = ~clk;

    input_symbol_feeder #(.DEPTH(DEPTH), .BUB_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_fl(in_fl), .in_fh(in_fh), .in_symbol(in_symbol), .in_nsyms(in_nsyms),
        .in_bool(in_bool), .in_last(in_last), .load_en(load_en), .out_valid(out_valid),
        .out_fl(out_fl), .out_fh(out_fh), .out_symbol(out_symbol), .out_nsyms(out_nsyms),
        .out_bool(out_bool), .out_last(out_last), .fifo_count(fifo_count),
        .bubble_cnt(bubble_cnt), .stream_done(stream_done)
    );

    input_symbol_feeder #(.DEPTH(DEPTH), .BUB_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_fl(in_fl), .in_fh(in_fh), .in_symbol(in_symbol), .in_nsyms(in_nsyms),
        .in_bool(in_bool), .in_last(in_last), .load_en(load_en), .out_valid(out_valid2),
        .out_fl(out_fl2), .out_fh(out_fh2), .out_symbol(out_symbol2), .out_nsyms(out_nsyms2),
        .out_bool(out_bool2), .out_last(out_last2), .fifo_count(fifo_count2),
        .bubble_cnt(bubble_cnt2), .stream_done(stream_done2)
    );

    int checks = 0;
    int errors = 0;

    sym_rec_t    sb[$];
    feed_state_t m_state = FEED_RUN;
    int          m_bub = 0;
    int          m_bub2 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic sym_rec_t mk(input logic [15:0] fl, input logic last);
        sym_rec_t r;
        r.fl     = fl;
        r.fh     = fl + 16'($urandom_range(1, 255));
        r.symbol = 4'($urandom);
        r.nsyms  = 5'($urandom_range(2, 16));
        r.bool   = 1'($urandom);
        r.last   = last;
        return r;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_state = FEED_RUN;
        m_bub   = 0;
        m_bub2  = 0;
    endtask

    // Drive one cycle: compare outputs with the model, clock, then advance the model.
    task automatic step(input logic v, input sym_rec_t r, input logic le);
        logic     exp_ready;
        logic     do_push;
        logic     do_pop;
        sym_rec_t head;
        sym_rec_t got;
        in_valid  = v;
        in_fl     = r.fl;
        in_fh     = r.fh;
        in_symbol = r.symbol;
        in_nsyms  = r.nsyms;
        in_bool   = r.bool;
        in_last   = r.last;
        load_en   = le;
        exp_ready = (m_state == FEED_RUN) && (sb.size() < DEPTH);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check("fifo_count", 64'(fifo_count), 64'(sb.size()));
        check("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
        check("bubble_sat", 64'(bubble_cnt2), 64'(m_bub2));
        check("stream_done", 64'(stream_done), 64'(m_state == FEED_DONE));
        do_push = v && exp_ready;
        do_pop  = le && (sb.size() != 0);
        head    = '0;
        if (sb.size() != 0) begin
            got = '{fl: out_fl, fh: out_fh, symbol: out_symbol, nsyms: out_nsyms,
                    bool: out_bool, last: out_last};
            head = sb[0];
            check("head_rec", 64'(got), 64'(head));
        end
        @(posedge clk);
        #1;
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back(r);
        if (le && !do_pop) begin
            if (m_bub < 65535) m_bub++;
            if (m_bub2 < 3) m_bub2++;
        end
        case (m_state)
            FEED_RUN:   if (do_push && r.last)    m_state = FEED_DRAIN;
            FEED_DRAIN: if (do_pop && head.last)  m_state = FEED_DONE;
            default:    m_state = FEED_RUN;
        endcase
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        load_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        sym_rec_t idle;
        idle = '0;

        // Test 1: three records issued in order on alternating load_en
        apply_reset();
        step(1'b1, mk(16'h1000, 1'b0), 1'b0);
        step(1'b1, mk(16'h2000, 1'b0), 1'b1);
        step(1'b1, mk(16'h3000, 1'b0), 1'b0);
        step(1'b0, idle, 1'b1);
        step(1'b0, idle, 1'b0);
        step(1'b0, idle, 1'b1);
        check("t1_empty", 64'(fifo_count), 64'd0);
        check("t1_no_bubble", 64'(bubble_cnt), 64'd0);

        // Test 3: five bubbles on an empty FIFO; the 2-bit counter saturates
        for (int i = 0; i < 5; i++) begin
            step(1'b0, idle, 1'b1);
            step(1'b0, idle, 1'b0);
        end
        check("t3_bubble5", 64'(bubble_cnt), 64'd5);
        check("t3_bubble_sat", 64'(bubble_cnt2), 64'd3);
        check("t3_out_valid", 64'(out_valid), 64'd0);

        // Test 2: fill, then pop while offering a record that must be refused
        for (int i = 0; i < DEPTH; i++) step(1'b1, mk(16'(i * 16'h0111), 1'b0), 1'b0);
        check("t2_full_count", 64'(fifo_count), 64'd16);
        check("t2_full_ready", 64'(in_ready), 64'd0);
        step(1'b1, mk(16'hdead, 1'b0), 1'b1);
        check("t2_after_count", 64'(fifo_count), 64'd15);
        check("t2_after_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 15; i++) step(1'b0, idle, 1'b1);

        // Test 4: end-of-stream gating and the done pulse
        for (int i = 0; i < 4; i++) step(1'b1, mk(16'h4000 + 16'(i), i == 3), 1'b0);
        check("t4_ready_low", 64'(in_ready), 64'd0);
        step(1'b1, mk(16'hbeef, 1'b0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t4_no_done_yet", 64'(stream_done), 64'd0);
            step(1'b1, mk(16'hbad0 + 16'(i), 1'b0), 1'b1);
        end
        check("t4_done_pulse", 64'(stream_done), 64'd1);
        check("t4_ready_in_done", 64'(in_ready), 64'd0);
        step(1'b0, idle, 1'b0);
        check("t4_done_clear", 64'(stream_done), 64'd0);
        check("t4_ready_back", 64'(in_ready), 64'd1);
        step(1'b0, idle, 1'b0);

        // Test 5: simultaneous push/pop across the pointer wrap at count 1
        apply_reset();
        step(1'b1, mk(16'h5000, 1'b0), 1'b0);
        for (int i = 1; i < DEPTH + 3; i++) begin
            step(1'b1, mk(16'h5000 + 16'(i), 1'b0), 1'b1);
            check("t5_count1", 64'(fifo_count), 64'd1);
        end
        step(1'b0, idle, 1'b1);
        check("t5_drained", 64'(fifo_count), 64'd0);

        // Test 6: asynchronous reset mid-DRAIN
        for (int i = 0; i < 7; i++) step(1'b1, mk(16'h6000 + 16'(i), i == 6), 1'b0);
        check("t6_count7", 64'(fifo_count), 64'd7);
        check("t6_drain_ready", 64'(in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_count", 64'(fifo_count), 64'd0);
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_done", 64'(stream_done), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_ready_after", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b0);
        step(1'b1, mk(16'h7000, 1'b0), 1'b0);
        step(1'b0, idle, 1'b1);
        step(1'b0, idle, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
